// File: rtl/vme_reg_bank.sv
// VME register bank: N_RW control registers, N_RO status registers with optional
// clear-on-read capture, and error strobes for unmapped or illegal accesses.
module vme_reg_bank #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_RW   = 2,
   parameter int unsigned N_RO   = 2,
   parameter logic [N_RW*DATA_W-1:0] RW_RESET = '0,
   parameter logic [63:0]            RO_STICKY = '0
) (
   input  logic                                   Clk,
   input  logic                                   Rst,
   input  logic [ADDR_W-3:0]                      VMEAddr,
   output logic [31:0]                            VMERdData,
   input  logic [31:0]                            VMEWrData,
   input  logic                                   VMERdMem,
   input  logic                                   VMEWrMem,
   output logic                                   VMERdDone,
   output logic                                   VMEWrDone,
   output logic                                   VMERdError,
   output logic                                   VMEWrError,
   output logic [N_RW*DATA_W-1:0]                 ctrl_o,
   output logic [N_RW-1:0]                        ctrl_wr_o,
   input  logic [(N_RO > 0 ? N_RO : 1)*DATA_W-1:0] status_i,
   output logic [(N_RO > 0 ? N_RO : 1)-1:0]        status_rd_o
);

   localparam int unsigned AW    = ADDR_W - 2;
   localparam int unsigned NRO_E = (N_RO > 0) ? N_RO : 1;

   logic              wr_v_q;
   logic [AW-1:0]     wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic [N_RW-1:0]   wr_sel_c;

   logic                    rd_hit_c;
   logic [NRO_E-1:0]        rd_st_sel_c;
   logic [DATA_W-1:0]       rd_data_c;
   logic [DATA_W-1:0]       st_c;
   logic [DATA_W-1:0]       view_c;
   logic [NRO_E*DATA_W-1:0] cap_q;
   logic [NRO_E*DATA_W-1:0] cap_d;

   // Write bus bits above DATA_W are intentionally dropped.
   logic unused_wr_c;
   assign unused_wr_c = ^VMEWrData;

   // Write decode: only control indices are writable.
   always_comb begin
      wr_sel_c = '0;
      for (int unsigned i = 0; i < N_RW; i++) begin
         if (wr_v_q && (wr_addr_q == AW'(i))) wr_sel_c[i] = 1'b1;
      end
   end

   // Read decode, read mux and sticky capture update.
   always_comb begin
      rd_hit_c    = 1'b0;
      rd_st_sel_c = '0;
      rd_data_c   = '0;
      st_c        = '0;
      view_c      = '0;
      cap_d       = '0;
      for (int unsigned i = 0; i < N_RW; i++) begin
         if (VMEAddr == AW'(i)) begin
            rd_hit_c  = 1'b1;
            rd_data_c = ctrl_o[i*DATA_W +: DATA_W];
         end
      end
      for (int unsigned j = 0; j < N_RO; j++) begin
         st_c   = status_i[j*DATA_W +: DATA_W];
         view_c = RO_STICKY[j] ? (cap_q[j*DATA_W +: DATA_W] | st_c) : st_c;
         if (VMEAddr == AW'(N_RW + j)) begin
            rd_hit_c       = 1'b1;
            rd_data_c      = view_c;
            rd_st_sel_c[j] = VMERdMem;
         end
         // A clearing read still keeps bits that are high in the same cycle.
         if (RO_STICKY[j])
            cap_d[j*DATA_W +: DATA_W] = rd_st_sel_c[j] ? st_c : view_c;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_v_q      <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ctrl_o      <= RW_RESET;
         ctrl_wr_o   <= '0;
         VMEWrDone   <= 1'b0;
         VMEWrError  <= 1'b0;
         VMERdData   <= '0;
         VMERdDone   <= 1'b0;
         VMERdError  <= 1'b0;
         status_rd_o <= '0;
         cap_q       <= '0;
      end else begin
         wr_v_q <= VMEWrMem;
         if (VMEWrMem) begin
            wr_addr_q <= VMEAddr;
            wr_data_q <= VMEWrData[DATA_W-1:0];
         end
         for (int unsigned i = 0; i < N_RW; i++) begin
            if (wr_sel_c[i]) ctrl_o[i*DATA_W +: DATA_W] <= wr_data_q;
         end
         ctrl_wr_o  <= wr_sel_c;
         VMEWrDone  <= |wr_sel_c;
         VMEWrError <= wr_v_q && !(|wr_sel_c);

         if (VMERdMem) VMERdData <= rd_hit_c ? 32'(rd_data_c) : 32'h0;
         VMERdDone   <= VMERdMem && rd_hit_c;
         VMERdError  <= VMERdMem && !rd_hit_c;
         status_rd_o <= rd_st_sel_c;
         cap_q       <= cap_d;
      end
   end

endmodule

// File: tb/tb_vme_reg_bank.sv
// Directed plus random bench for vme_reg_bank (DATA_W=16, two control, two status,
// status0 sticky) against a latency-based reference model.
module tb_vme_reg_bank;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [17:0] VMEAddr = '0;
   logic [31:0] VMERdData;
   logic [31:0] VMEWrData = '0;
   logic        VMERdMem = 1'b0;
   logic        VMEWrMem = 1'b0;
   logic        VMERdDone, VMEWrDone, VMERdError, VMEWrError;
   logic [31:0] ctrl_o;
   logic [1:0]  ctrl_wr_o;
   logic [31:0] status_i = '0;
   logic [1:0]  status_rd_o;

   vme_reg_bank #(
      .ADDR_W(20), .DATA_W(16), .N_RW(2), .N_RO(2),
      .RW_RESET(32'h00A5_1234), .RO_STICKY(64'h1)
   ) dut (
      .Clk(Clk), .Rst(Rst), .VMEAddr(VMEAddr), .VMERdData(VMERdData),
      .VMEWrData(VMEWrData), .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
      .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone), .VMERdError(VMERdError),
      .VMEWrError(VMEWrError), .ctrl_o(ctrl_o), .ctrl_wr_o(ctrl_wr_o),
      .status_i(status_i), .status_rd_o(status_rd_o)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [15:0] ctrl_m [2];
   logic [15:0] cap_m;
   logic        pend_v;
   logic [17:0] pend_a;
   logic [15:0] pend_d;
   logic [31:0] e_rdata;
   logic        e_rdone, e_rerr, e_wdone, e_werr;
   logic [1:0]  e_cwr, e_srd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".ctrl_o"},   ctrl_o, {ctrl_m[1], ctrl_m[0]});
      check({tag, ".ctrl_wr"},  32'(ctrl_wr_o), 32'(e_cwr));
      check({tag, ".wr_done"},  32'(VMEWrDone), 32'(e_wdone));
      check({tag, ".wr_err"},   32'(VMEWrError), 32'(e_werr));
      check({tag, ".rd_done"},  32'(VMERdDone), 32'(e_rdone));
      check({tag, ".rd_err"},   32'(VMERdError), 32'(e_rerr));
      check({tag, ".rd_data"},  VMERdData, e_rdata);
      check({tag, ".st_rd"},    32'(status_rd_o), 32'(e_srd));
   endtask

   task automatic rst_tick(input string tag);
      Rst = 1'b1; VMERdMem = 1'b0; VMEWrMem = 1'b0; VMEAddr = '0;
      VMEWrData = '0; status_i = '0;
      ctrl_m[0] = 16'h1234; ctrl_m[1] = 16'h00A5; cap_m = '0; pend_v = 1'b0;
      e_rdata = '0; e_rdone = 0; e_rerr = 0; e_wdone = 0; e_werr = 0; e_cwr = '0; e_srd = '0;
      @(posedge Clk); #1;
      check_all(tag);
   endtask

   task automatic tick(input string tag, input logic rd, input logic wr, input logic [17:0] a,
                       input logic [31:0] wd, input logic [15:0] s0, input logic [15:0] s1);
      logic sticky_read;
      Rst = 1'b0; VMERdMem = rd; VMEWrMem = wr; VMEAddr = a; VMEWrData = wd;
      status_i = {s1, s0};
      e_rdone = 0; e_rerr = 0; e_wdone = 0; e_werr = 0; e_cwr = '0; e_srd = '0;
      sticky_read = 1'b0;
      // read sees register contents before any commit at this edge
      if (rd) begin
         if (a < 18'd2) begin
            e_rdone = 1; e_rdata = {16'h0, ctrl_m[a[0]]};
         end else if (a == 18'd2) begin
            e_rdone = 1; e_rdata = {16'h0, cap_m | s0}; e_srd = 2'b01; sticky_read = 1'b1;
         end else if (a == 18'd3) begin
            e_rdone = 1; e_rdata = {16'h0, s1}; e_srd = 2'b10;
         end else begin
            e_rerr = 1; e_rdata = '0;
         end
      end
      cap_m = sticky_read ? s0 : (cap_m | s0);
      if (pend_v) begin
         if (pend_a < 18'd2) begin
            ctrl_m[pend_a[0]] = pend_d; e_cwr[pend_a[0]] = 1'b1; e_wdone = 1;
         end else begin
            e_werr = 1;
         end
      end
      pend_v = wr; pend_a = a; pend_d = wd[15:0];
      @(posedge Clk); #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      tick(tag, 1'b0, 1'b0, 18'h0, 32'h0, 16'h0, 16'h0);
   endtask

   initial begin
      logic        rd, wr;
      logic [17:0] a;
      logic [15:0] s0;
      rst_tick("reset0");
      rst_tick("reset1");
      tick("rd_idx0", 1, 0, 18'd0, 32'h0, 16'h0, 16'h0);
      check("rd_idx0_val", VMERdData, 32'h0000_1234);

      tick("wr_idx1_T", 0, 1, 18'd1, 32'hDEAD_BEEF, 16'h0, 16'h0);
      idle("wr_idx1_T1");
      idle("wr_idx1_T2");
      check("wr_idx1_ctrl", ctrl_o, 32'hBEEF_1234);
      tick("rd_idx1", 1, 0, 18'd1, 32'h0, 16'h0, 16'h0);
      check("rd_idx1_val", VMERdData, 32'h0000_BEEF);

      tick("wr_st", 0, 1, 18'd2, 32'h1111_1111, 16'h0, 16'h0);
      tick("wr_unm", 0, 1, 18'h3FFFF, 32'h2222_2222, 16'h0, 16'h0);
      idle("wr_st_resp");
      idle("wr_unm_resp");
      tick("rd_unm", 1, 0, 18'h3FFFF, 32'h0, 16'h0, 16'h0);
      check("rd_unm_err", 32'(VMERdError), 32'h1);
      tick("rd_st1", 1, 0, 18'd3, 32'h0, 16'h0, 16'h5A5A);

      tick("stk_pulse", 0, 0, 18'd0, 32'h0, 16'h0004, 16'h0);
      idle("stk_gap");
      tick("stk_rd1", 1, 0, 18'd2, 32'h0, 16'h0, 16'h0);
      check("stk_rd1_val", VMERdData, 32'h0000_0004);
      tick("stk_rd2", 1, 0, 18'd2, 32'h0, 16'h0, 16'h0);
      check("stk_rd2_val", VMERdData, 32'h0);
      tick("stk_hold", 0, 0, 18'd0, 32'h0, 16'h0001, 16'h0);
      tick("stk_rd3", 1, 0, 18'd2, 32'h0, 16'h0001, 16'h0);
      tick("stk_rd4", 1, 0, 18'd2, 32'h0, 16'h0001, 16'h0);
      check("stk_rd4_val", VMERdData, 32'h0000_0001);
      idle("stk_done");

      for (int v = 1; v <= 4; v++)
         tick("b2b", 1, 1, 18'd0, 32'(v), 16'h0, 16'h0);
      idle("b2b_drain1");
      idle("b2b_drain2");
      check("b2b_final", ctrl_o[15:0], 16'd4);

      tick("rst_mid_T", 0, 1, 18'd0, 32'h5555_5555, 16'h0, 16'h0);
      rst_tick("rst_mid");
      idle("rst_mid_after");
      check("rst_mid_ctrl0", ctrl_o[15:0], 16'h1234);

      for (int n = 0; n < 300; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: a = 18'd0;
            1: a = 18'd1;
            2: a = 18'd2;
            3: a = 18'd3;
            4: a = 18'd4;
            default: a = 18'($urandom);
         endcase
         s0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
         tick("rand", rd, wr, a, $urandom, s0, 16'($urandom));
      end
      idle("rand_drain1");
      idle("rand_drain2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
